// File: rtl/ifu_axil_fetch.sv
// Instruction-fetch unit: takes one pc per handshake, reads the word over an
// AXI4-Lite read channel and holds it for the decode stage. Misaligned pcs and
// non-OKAY read responses are reported as a fault carrying a NOP instruction.
module ifu_axil_fetch #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] FAULT_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {IDLE, AR, R, HOLD} state_t;

  state_t state;
  state_t next_state;
  logic   accept;
  logic   misaligned;

  // Handshake outputs come from the state alone so nothing combinationally
  // follows s_valid or rvalid; s_ready may follow m_ready to allow
  // back-to-back fetches out of HOLD.
  assign s_ready    = (state == IDLE) | ((state == HOLD) & m_ready);
  assign accept     = s_valid & s_ready;
  assign misaligned = (pc[1:0] != 2'b00);
  assign arvalid    = (state == AR);
  assign rready     = (state == R);
  assign m_valid    = (state == HOLD);

  // State register; reset drops any in-flight beat by returning to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a misaligned request skips the bus and goes straight to HOLD.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = misaligned ? HOLD : AR;
        end
      end
      AR: begin
        if (arready) begin
          next_state = R;
        end
      end
      R: begin
        if (rvalid) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          if (accept) begin
            next_state = misaligned ? HOLD : AR;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture the request on accept and the read beat in R.
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr  <= '0;
      inst    <= '0;
      inst_pc <= '0;
      fault   <= 1'b0;
    end else begin
      if (accept) begin
        inst_pc <= pc;
        if (misaligned) begin
          inst  <= FAULT_INST;
          fault <= 1'b1;
        end else begin
          araddr <= pc;
        end
      end
      if ((state == R) && rvalid) begin
        if (rresp == 2'b00) begin
          inst  <= rdata;
          fault <= 1'b0;
        end else begin
          inst  <= FAULT_INST;
          fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_axil_fetch.sv
// Directed self-checking bench for ifu_axil_fetch. Inputs change just after
// the falling edge; outputs are checked there, away from the rising edge.
module tb_ifu_axil_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;
  logic        m_valid;
  logic        m_ready;

  int errors = 0;
  int checks = 0;
  int ar_count = 0;
  int violations = 0;
  logic ar_pending = 1'b0;

  logic [31:0] b2b_pc   [3] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
  logic [31:0] b2b_data [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
  logic [31:0] offset;
  int ar_snap;
  int idx;
  int n;

  ifu_axil_fetch dut (
    .clk     (clk),
    .rst     (rst),
    .pc      (pc),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .inst    (inst),
    .inst_pc (inst_pc),
    .fault   (fault),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count AR handshakes and flag protocol violations seen on any rising edge.
  always @(posedge clk) begin
    if (rst) begin
      ar_pending = 1'b0;
    end else begin
      if (arvalid && arready) ar_count++;
      if (m_valid && (arvalid || rready)) violations++;
      if (ar_pending && !arvalid) violations++;
      ar_pending = arvalid && !arready;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [31:0] p, input logic ar,
                               input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                               input logic mr);
    s_valid = sv;
    pc      = p;
    arready = ar;
    rvalid  = rv;
    rdata   = rd;
    rresp   = rr;
    m_ready = mr;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);
    repeat (2) tick();
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_rready",  rready,  0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_fault",   fault,   0);
    checkOutput("rst_inst",    inst,    32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_araddr",  araddr,  32'h0);

    // Reset held two cycles while in R, with a beat offered that must be dropped
    rst = 1'b0;
    applyStimulus(1, 32'h0000_0100, 1, 0, 32'h0, 2'b00, 0);
    tick();
    checkOutput("midrst_arvalid", arvalid, 1);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 2'b00, 0);
    tick();
    checkOutput("midrst_rready", rready, 1);
    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 1, 32'hBAD0_0BAD, 2'b00, 0);
    repeat (2) tick();
    rst = 1'b0;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);
    checkOutput("midrst_arvalid0", arvalid, 0);
    checkOutput("midrst_rready0",  rready,  0);
    checkOutput("midrst_m_valid0", m_valid, 0);
    checkOutput("midrst_s_ready",  s_ready, 1);
    tick();
    checkOutput("midrst_idle_mv", m_valid, 0);
    checkOutput("midrst_inst",    inst,    32'h0);

    // Single aligned fetch: accept c0, arvalid c1, rready c2, m_valid c3
    applyStimulus(1, 32'h8000_0000, 1, 0, 32'h0, 2'b00, 0);
    #1 checkOutput("single_s_ready", s_ready, 1);
    tick();
    checkOutput("single_c1_arvalid", arvalid, 1);
    checkOutput("single_c1_araddr",  araddr,  32'h8000_0000);
    checkOutput("single_c1_m_valid", m_valid, 0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 2'b00, 0);
    tick();
    checkOutput("single_c2_rready",  rready,  1);
    checkOutput("single_c2_arvalid", arvalid, 0);
    checkOutput("single_c2_m_valid", m_valid, 0);
    applyStimulus(0, 32'h0, 0, 1, 32'h0010_0093, 2'b00, 0);
    tick();
    checkOutput("single_c3_m_valid", m_valid, 1);
    checkOutput("single_inst",       inst,    32'h0010_0093);
    checkOutput("single_inst_pc",    inst_pc, 32'h8000_0000);
    checkOutput("single_fault",      fault,   0);
    checkOutput("single_c3_arvalid", arvalid, 0);
    checkOutput("single_c3_rready",  rready,  0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);
    #1 checkOutput("hold_s_ready_lo", s_ready, 0);
    m_ready = 1'b1;
    #1 checkOutput("hold_s_ready_hi", s_ready, 1);
    tick();
    checkOutput("single_idle_m_valid", m_valid, 0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);

    // Stalls: arready late 4 cycles, rvalid late 5 cycles, m_ready low 3 cycles
    ar_snap = ar_count;
    applyStimulus(1, 32'h8000_0010, 0, 0, 32'h0, 2'b00, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_ar_arvalid", arvalid, 1);
      checkOutput("stall_ar_araddr",  araddr,  32'h8000_0010);
      applyStimulus(0, 32'h0, 0, 1, 32'hFFFF_FFFF, 2'b00, 0);
      tick();
    end
    checkOutput("stall_ar_final", arvalid, 1);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 2'b00, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_r_rready",  rready,  1);
      checkOutput("stall_r_arvalid", arvalid, 0);
      checkOutput("stall_r_m_valid", m_valid, 0);
      applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);
      tick();
    end
    checkOutput("stall_r_final", rready, 1);
    applyStimulus(0, 32'h0, 0, 1, 32'h0020_0113, 2'b00, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_hold_m_valid", m_valid, 1);
      checkOutput("stall_hold_inst",    inst,    32'h0020_0113);
      checkOutput("stall_hold_inst_pc", inst_pc, 32'h8000_0010);
      checkOutput("stall_hold_fault",   fault,   0);
      applyStimulus(0, 32'h0, 0, 1, 32'hFFFF_FFFF, 2'b11, 0);
      tick();
    end
    checkOutput("stall_hold_final", inst, 32'h0020_0113);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 1);
    tick();
    checkOutput("stall_idle_m_valid", m_valid, 0);
    checkOutput("stall_ar_count", ar_count - ar_snap, 1);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);

    // Bus error response
    applyStimulus(1, 32'h8000_0020, 1, 0, 32'h0, 2'b00, 0);
    tick();
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 2'b00, 0);
    tick();
    checkOutput("berr_rready", rready, 1);
    applyStimulus(0, 32'h0, 0, 1, 32'hDEAD_BEEF, 2'b10, 0);
    tick();
    checkOutput("berr_m_valid", m_valid, 1);
    checkOutput("berr_inst",    inst,    32'h0000_0013);
    checkOutput("berr_fault",   fault,   1);
    checkOutput("berr_inst_pc", inst_pc, 32'h8000_0020);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 1);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);

    // Misaligned pc: no bus access, m_valid one cycle after accept
    ar_snap = ar_count;
    applyStimulus(1, 32'h8000_0002, 1, 0, 32'h0, 2'b00, 0);
    tick();
    checkOutput("mis_m_valid", m_valid, 1);
    checkOutput("mis_fault",   fault,   1);
    checkOutput("mis_inst",    inst,    32'h0000_0013);
    checkOutput("mis_inst_pc", inst_pc, 32'h8000_0002);
    checkOutput("mis_arvalid", arvalid, 0);
    checkOutput("mis_araddr",  araddr,  32'h8000_0020);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 2'b00, 1);
    tick();
    checkOutput("mis_idle_m_valid", m_valid, 0);
    checkOutput("mis_idle_arvalid", arvalid, 0);
    checkOutput("mis_ar_count", ar_count - ar_snap, 0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 2'b00, 0);

    // Back-to-back: s_valid held, m_ready high, responder answers in R
    ar_snap = ar_count;
    idx = 0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_valid) begin
        if (n < 3) begin
          checkOutput("b2b_inst",    inst,    b2b_data[n]);
          checkOutput("b2b_inst_pc", inst_pc, b2b_pc[n]);
        end
        checkOutput("b2b_fault", fault, 0);
        checkOutput("b2b_cycle", c, 3 * n + 3);
        n++;
      end
      offset = araddr - 32'h8000_0000;
      applyStimulus(idx < 3, (idx < 3) ? b2b_pc[idx] : 32'h0, 1, rready,
                    (offset[3:2] < 2'd3) ? b2b_data[offset[3:2]] : 32'h0, 2'b00, 1);
      #1;
      if (s_valid && s_ready) idx++;
      tick();
    end
    checkOutput("b2b_count",    n, 3);
    checkOutput("b2b_ar_count", ar_count - ar_snap, 3);
    checkOutput("b2b_idle",     m_valid, 0);
    checkOutput("protocol_violations", violations, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
